// File: rtl/ram_dp_clr.sv
`default_nettype none
// ============================================================================
// ram_dp_clr : dual-port RAM (A read/write with byte enables, B read-only)
//              with a one-word-per-cycle zero-clear sweep
// Revision   : 1.0
// ============================================================================
module ram_dp_clr #(
  parameter int    DATA_WIDTH     = 32,
  parameter int    ADDRESS_WIDTH  = 12,
  parameter int    DEPTH          = 4096,
  parameter string MEMFILE        = "",
  parameter int    READ_LATENCY   = 1,
  parameter int    RDW_MODE       = 0,
  parameter int    CLEAR_ON_RESET = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_en,
  input  logic                    a_we,
  input  logic [DATA_WIDTH/8-1:0] a_be,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]   a_din,
  output logic [DATA_WIDTH-1:0]   a_dout,
  output logic                    a_rvalid,
  input  logic                    b_en,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0]   b_dout,
  output logic                    b_rvalid,
  input  logic                    clr_req,
  output logic                    busy,
  output logic                    oor_err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH:0]   DEPTH_EXT = (ADDRESS_WIDTH + 1)'(DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [ADDRESS_WIDTH-1:0] sweep_addr;
  logic                     sweep_last;
  logic                     init_pending;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic                  a_acc;
  logic                  b_acc;
  logic                  a_in;
  logic                  b_in;
  logic                  a_wr;
  logic                  a_rd;
  logic [DATA_WIDTH-1:0] a_word;
  logic [DATA_WIDTH-1:0] b_word;
  logic [DATA_WIDTH-1:0] a_merged;
  logic [DATA_WIDTH-1:0] b_rdata;
  logic                  a_fin_v;
  logic                  b_fin_v;
  logic [DATA_WIDTH-1:0] a_fin_d;
  logic [DATA_WIDTH-1:0] b_fin_d;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BYTES-1:0]      be
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_word;
    for (int i = 0; i < BYTES; i++) begin
      if (be[i]) r[8*i +: 8] = new_word[8*i +: 8];
    end
    return r;
  endfunction

  assign busy  = (state == CLEAR);
  assign a_acc = a_en & ~busy;
  assign b_acc = b_en & ~busy;
  assign a_in  = ({1'b0, a_addr} < DEPTH_EXT);
  assign b_in  = ({1'b0, b_addr} < DEPTH_EXT);
  assign a_wr  = a_acc & a_we & a_in;
  assign a_rd  = a_acc & ~a_we;

  // Out-of-range reads return zero rather than touching the array.
  assign a_word   = a_in ? mem[a_addr[IDX_W-1:0]] : '0;
  assign b_word   = b_in ? mem[b_addr[IDX_W-1:0]] : '0;
  assign a_merged = merge_bytes(a_word, a_din, a_be);

  generate
    if (RDW_MODE == 1) begin : g_rdw_new
      assign b_rdata = (a_wr && (a_addr == b_addr)) ? merge_bytes(b_word, a_din, a_be) : b_word;
    end else begin : g_rdw_old
      assign b_rdata = b_word;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (busy) begin
      mem[sweep_addr[IDX_W-1:0]] <= '0;
    end else if (a_wr) begin
      mem[a_addr[IDX_W-1:0]] <= a_merged;
    end
  end

  assign sweep_last = (sweep_addr == LAST_ADDR);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clr_req || init_pending) state_next = CLEAR;
      CLEAR:   if (sweep_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sweep_addr   <= '0;
      init_pending <= (CLEAR_ON_RESET != 0);
    end else begin
      state        <= state_next;
      init_pending <= 1'b0;
      if (state == CLEAR) begin
        sweep_addr <= sweep_last ? '0 : sweep_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oor_err <= 1'b0;
    end else if ((a_acc && !a_in) || (b_acc && !b_in)) begin
      oor_err <= 1'b1;
    end
  end

  // Read data is captured at acceptance, so a sweep starting later cannot corrupt it.
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  a_v1;
      logic                  b_v1;
      logic [DATA_WIDTH-1:0] a_d1;
      logic [DATA_WIDTH-1:0] b_d1;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_v1 <= 1'b0;
          b_v1 <= 1'b0;
          a_d1 <= '0;
          b_d1 <= '0;
        end else begin
          a_v1 <= a_rd;
          b_v1 <= b_acc;
          if (a_rd)  a_d1 <= a_word;
          if (b_acc) b_d1 <= b_rdata;
        end
      end

      assign a_fin_v = a_v1;
      assign b_fin_v = b_v1;
      assign a_fin_d = a_d1;
      assign b_fin_d = b_d1;
    end else begin : g_lat1
      assign a_fin_v = a_rd;
      assign b_fin_v = b_acc;
      assign a_fin_d = a_word;
      assign b_fin_d = b_rdata;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_dout   <= '0;
      b_dout   <= '0;
    end else begin
      a_rvalid <= a_fin_v;
      b_rvalid <= b_fin_v;
      if (a_fin_v) a_dout <= a_fin_d;
      if (b_fin_v) b_dout <= b_fin_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_dp_clr.sv
`default_nettype none
// Two ram_dp_clr instances (16 words/latency 1/old-data, 3000 words/latency 2/new-data)
// share one stimulus stream; a reference model and read scoreboard check both.
module tb_ram_dp_clr;

  typedef struct {
    int          d;
    int          p;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        a_en = 1'b0;
  logic        a_we = 1'b0;
  logic [3:0]  a_be = 4'h0;
  logic [11:0] a_addr = '0;
  logic [31:0] a_din = '0;
  logic        b_en = 1'b0;
  logic [11:0] b_addr = '0;
  logic        clr_req = 1'b0;

  logic [31:0] a_dout [2];
  logic [31:0] b_dout [2];
  logic        a_rvalid [2];
  logic        b_rvalid [2];
  logic        busy_o [2];
  logic        oor_o [2];

  logic [31:0] mm [2][4096];
  bit          busy_m [2];
  int          sw_m [2];
  bit          oor_m [2];
  logic [31:0] last_m [2][2];
  exp_t        sq[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  ram_dp_clr #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .DEPTH(16), .MEMFILE(""),
               .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
    .a_din(a_din), .a_dout(a_dout[0]), .a_rvalid(a_rvalid[0]), .b_en(b_en), .b_addr(b_addr),
    .b_dout(b_dout[0]), .b_rvalid(b_rvalid[0]), .clr_req(clr_req), .busy(busy_o[0]),
    .oor_err(oor_o[0]));

  ram_dp_clr #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .DEPTH(3000), .MEMFILE(""),
               .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
    .a_din(a_din), .a_dout(a_dout[1]), .a_rvalid(a_rvalid[1]), .b_en(b_en), .b_addr(b_addr),
    .b_dout(b_dout[1]), .b_rvalid(b_rvalid[1]), .clr_req(clr_req), .busy(busy_o[1]),
    .oor_err(oor_o[1]));

  function automatic int dep(input int d);
    return (d == 0) ? 16 : 3000;
  endfunction
  function automatic int lat(input int d);
    return (d == 0) ? 1 : 2;
  endfunction
  function automatic int rdw(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) o[8*i +: 8] = n[8*i +: 8];
    return o;
  endfunction

  // Advance the model by one edge using the inputs now applied, then check both DUTs.
  task automatic tick();
    exp_t        e;
    logic        aa, ba, ai, bi, rv;
    logic [31:0] dv;
    int          idx;
    for (int d = 0; d < 2; d++) begin
      aa = a_en && !busy_m[d];
      ba = b_en && !busy_m[d];
      ai = (int'(a_addr) < dep(d));
      bi = (int'(b_addr) < dep(d));
      if (ba) begin
        e.d = d; e.p = 1; e.due = cyc + lat(d);
        e.data = bi ? mm[d][b_addr] : 32'h0;
        if (rdw(d) == 1 && aa && a_we && ai && a_addr == b_addr) e.data = mrg(e.data, a_din, a_be);
        sq.push_back(e);
      end
      if (aa && !a_we) begin
        e.d = d; e.p = 0; e.due = cyc + lat(d);
        e.data = ai ? mm[d][a_addr] : 32'h0;
        sq.push_back(e);
      end
      if (aa && a_we && ai) mm[d][a_addr] = mrg(mm[d][a_addr], a_din, a_be);
      if ((aa && !ai) || (ba && !bi)) oor_m[d] = 1'b1;
      if (busy_m[d]) begin
        mm[d][sw_m[d]] = 32'h0;
        sw_m[d]++;
        if (sw_m[d] == dep(d)) begin
          busy_m[d] = 1'b0;
          sw_m[d]   = 0;
        end
      end else if (clr_req) begin
        busy_m[d] = 1'b1;
        sw_m[d]   = 0;
      end
    end

    @(posedge clk);
    #1;
    cyc++;

    for (int d = 0; d < 2; d++) begin
      tests++;
      if (busy_o[d] !== busy_m[d]) begin
        fails++;
        $display("FAIL busy dut%0d cyc %0d: got %b want %b", d, cyc, busy_o[d], busy_m[d]);
      end
      tests++;
      if (oor_o[d] !== oor_m[d]) begin
        fails++;
        $display("FAIL oor_err dut%0d cyc %0d: got %b want %b", d, cyc, oor_o[d], oor_m[d]);
      end
      for (int p = 0; p < 2; p++) begin
        rv = (p == 0) ? a_rvalid[d] : b_rvalid[d];
        dv = (p == 0) ? a_dout[d] : b_dout[d];
        tests++;
        if (rv === 1'b1) begin
          idx = -1;
          for (int i = 0; i < sq.size(); i++) begin
            if (sq[i].d == d && sq[i].p == p) begin
              idx = i;
              break;
            end
          end
          if (idx < 0) begin
            fails++;
            $display("FAIL unexpected rvalid dut%0d port%0d cyc %0d: got data %h", d, p, cyc, dv);
            last_m[d][p] = dv;
          end else begin
            e = sq[idx];
            sq.delete(idx);
            if (dv !== e.data || e.due != cyc) begin
              fails++;
              $display("FAIL read dut%0d port%0d cyc %0d: got %h want %h (due cyc %0d)",
                       d, p, cyc, dv, e.data, e.due);
            end
            last_m[d][p] = e.data;
          end
        end else if (rv !== 1'b0 || dv !== last_m[d][p]) begin
          fails++;
          $display("FAIL hold dut%0d port%0d cyc %0d: got rvalid %b dout %h want 0 %h",
                   d, p, cyc, rv, dv, last_m[d][p]);
        end
      end
    end

    idx = 0;
    while (idx < sq.size()) begin
      if (sq[idx].due <= cyc) begin
        tests++;
        fails++;
        $display("FAIL missing rvalid dut%0d port%0d cyc %0d: got none want %h",
                 sq[idx].d, sq[idx].p, cyc, sq[idx].data);
        sq.delete(idx);
      end else begin
        idx++;
      end
    end
  endtask

  task automatic drive(input logic ae, input logic we, input logic [3:0] be, input logic [11:0] aa,
                       input logic [31:0] din, input logic bee, input logic [11:0] ba, input logic clr);
    a_en = ae; a_we = we; a_be = be; a_addr = aa; a_din = din;
    b_en = bee; b_addr = ba; clr_req = clr;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 4'h0, 12'd0, 32'h0, 0, 12'd0, 0);
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 16; i++) drive(1, 1, 4'hF, 12'(i), base + 32'(i), 0, 12'd0, 0);
  endtask

  task automatic apply_reset();
    a_en = 0; a_we = 0; a_be = 0; a_addr = 0; a_din = 0; b_en = 0; b_addr = 0; clr_req = 0;
    rst_n = 1'b0;
    #1;
    sq.delete();
    for (int d = 0; d < 2; d++) begin
      busy_m[d] = 0; sw_m[d] = 0; oor_m[d] = 0;
      last_m[d][0] = 32'h0; last_m[d][1] = 32'h0;
      tests++;
      if ({a_dout[d], b_dout[d], a_rvalid[d], b_rvalid[d], busy_o[d], oor_o[d]} !== 68'h0) begin
        fails++;
        $display("FAIL reset outputs dut%0d: got a_dout %h b_dout %h rv %b%b busy %b oor %b want all 0",
                 d, a_dout[d], b_dout[d], a_rvalid[d], b_rvalid[d], busy_o[d], oor_o[d]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    idle(2);
  endtask

  task automatic test_write_read();
    drive(1, 1, 4'hF, 12'd5, 32'hAABBCCDD, 0, 12'd0, 0);
    drive(1, 0, 4'h0, 12'd5, 32'h0, 0, 12'd0, 0);
    idle(3);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (a_dout[d] !== 32'hAABBCCDD) begin
        fails++;
        $display("FAIL write_read dut%0d: got %h want aabbccdd", d, a_dout[d]);
      end
    end
  endtask

  task automatic test_byte_enable();
    drive(1, 1, 4'b0101, 12'd5, 32'h11223344, 0, 12'd0, 0);
    drive(1, 0, 4'h0, 12'd5, 32'h0, 0, 12'd0, 0);
    idle(3);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (a_dout[d] !== 32'hAA22CC44) begin
        fails++;
        $display("FAIL byte_enable dut%0d: got %h want aa22cc44", d, a_dout[d]);
      end
    end
    drive(1, 1, 4'b0000, 12'd5, 32'h0, 0, 12'd0, 0);
    drive(0, 0, 4'h0, 12'd0, 32'h0, 1, 12'd5, 0);
    idle(3);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (b_dout[d] !== 32'hAA22CC44) begin
        fails++;
        $display("FAIL be_zero dut%0d: got %h want aa22cc44", d, b_dout[d]);
      end
    end
  endtask

  task automatic test_rdw();
    drive(1, 1, 4'hF, 12'd7, 32'h0, 0, 12'd0, 0);
    drive(1, 1, 4'hF, 12'd7, 32'hFFFFFFFF, 1, 12'd7, 0);
    idle(3);
    tests++;
    if (b_dout[0] !== 32'h0) begin
      fails++;
      $display("FAIL rdw_old dut0: got %h want 00000000", b_dout[0]);
    end
    tests++;
    if (b_dout[1] !== 32'hFFFFFFFF) begin
      fails++;
      $display("FAIL rdw_new dut1: got %h want ffffffff", b_dout[1]);
    end
  endtask

  task automatic test_oor();
    drive(1, 0, 4'h0, 12'd3500, 32'h0, 1, 12'd3500, 0);
    idle(3);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (a_dout[d] !== 32'h0 || b_dout[d] !== 32'h0 || oor_o[d] !== 1'b1) begin
        fails++;
        $display("FAIL oor_read dut%0d: got a %h b %h oor %b want 0 0 1", d, a_dout[d], b_dout[d], oor_o[d]);
      end
    end
    drive(1, 1, 4'hF, 12'd3500, 32'hDEADBEEF, 0, 12'd0, 0);
    for (int i = 0; i < 16; i++) drive(1, 0, 4'h0, 12'(i), 32'h0, 1, 12'(15 - i), 0);
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic [11:0] aa, ba;
    for (int i = 0; i < 300; i++) begin
      aa = ($urandom_range(15) == 0) ? 12'd3500 : 12'($urandom_range(15));
      ba = ($urandom_range(15) == 0) ? 12'd3500 : 12'($urandom_range(15));
      drive(1'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom_range(15)), aa,
            $urandom, 1'($urandom_range(1)), ba, 0);
    end
    idle(3);
    tests++;
    if (sq.size() != 0) begin
      fails++;
      $display("FAIL back_to_back drain: got %0d pending want 0", sq.size());
    end
  endtask

  task automatic test_clear();
    int nbusy;
    fill(32'hC0DE0100);
    drive(1, 0, 4'h0, 12'd3, 32'h0, 1, 12'd4, 1);
    nbusy = (busy_o[0] === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 14) drive(1, 1, 4'hF, 12'(i), 32'hFFFFFFFF, 1, 12'(i), 0);
      else idle(1);
      if (busy_o[0] === 1'b1) nbusy++;
    end
    tests++;
    if (nbusy != 16) begin
      fails++;
      $display("FAIL clear busy cycles dut0: got %0d want 16", nbusy);
    end
    for (int i = 0; i < 16; i++) drive(1, 0, 4'h0, 12'(i), 32'h0, 1, 12'(15 - i), 0);
    for (int k = 0; k < 3100 && busy_m[1]; k++) idle(1);
    tests++;
    if (busy_o[1] !== 1'b0) begin
      fails++;
      $display("FAIL clear timeout dut1: got busy %b want 0", busy_o[1]);
    end
    for (int i = 0; i < 16; i++) drive(1, 0, 4'h0, 12'(i), 32'h0, 1, 12'(i), 0);
    drive(1, 0, 4'h0, 12'd2999, 32'h0, 0, 12'd0, 0);
    idle(3);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (a_dout[d] !== 32'h0) begin
        fails++;
        $display("FAIL clear last word dut%0d: got %h want 0", d, a_dout[d]);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    fill(32'h5A5A0000);
    drive(0, 0, 4'h0, 12'd0, 32'h0, 0, 12'd0, 1);
    idle(8);
    apply_reset();
    idle(1);
    for (int i = 0; i < 16; i++) drive(1, 0, 4'h0, 12'(i), 32'h0, 1, 12'(15 - i), 0);
    drive(1, 0, 4'h0, 12'd7, 32'h0, 1, 12'd9, 0);
    idle(3);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (a_dout[d] !== 32'h0 || b_dout[d] !== 32'h5A5A0009) begin
        fails++;
        $display("FAIL mid_sweep reset dut%0d: got w7 %h w9 %h want 00000000 5a5a0009",
                 d, a_dout[d], b_dout[d]);
      end
    end
  endtask

  initial begin
    #3;
    test_reset();
    fill(32'h01010000);
    test_write_read();
    test_byte_enable();
    test_rdw();
    test_oor();
    test_back_to_back();
    test_clear();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ram_dp_clr.md
RAM_DP_CLR -- requirements
Module: ram_dp_clr

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 SHALL provide parameter ADDRESS_WIDTH, default 12, address width of both ports.
REQ-003 SHALL provide parameter DEPTH, default 4096, number of words; DEPTH <= 2^ADDRESS_WIDTH.
REQ-004 SHALL provide parameter MEMFILE, default "", hex image loaded at elaboration when non-empty.
REQ-005 SHALL provide parameter READ_LATENCY, default 1, legal values 1 or 2, cycles from accepted read to rvalid.
REQ-006 SHALL provide parameter RDW_MODE, default 0; 0 = old data on same-address A-write/B-read, 1 = new data.
REQ-007 SHALL provide parameter CLEAR_ON_RESET, default 0; 1 = automatic clear sweep after reset release.
REQ-008 clk  input  1  single clock; all state updates on rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 a_en  input  1  port A request strobe.
REQ-011 a_we  input  1  port A write (1) / read (0).
REQ-012 a_be  input  DATA_WIDTH/8  port A byte enables; bit i gates byte i.
REQ-013 a_addr  input  ADDRESS_WIDTH  port A word address.
REQ-014 a_din  input  DATA_WIDTH  port A write data.
REQ-015 a_dout  output  DATA_WIDTH  port A read data.
REQ-016 a_rvalid  output  1  port A read data valid, one-cycle pulse.
REQ-017 b_en  input  1  port B read request strobe (read-only port).
REQ-018 b_addr  input  ADDRESS_WIDTH  port B word address.
REQ-019 b_dout  output  DATA_WIDTH  port B read data.
REQ-020 b_rvalid  output  1  port B read data valid, one-cycle pulse.
REQ-021 clr_req  input  1  request full-memory zero sweep.
REQ-022 busy  output  1  high while clear sweep runs.
REQ-023 oor_err  output  1  sticky flag: any accepted request with address >= DEPTH.

Function
REQ-024 SHALL accept a port request in a cycle where its en=1 and busy=0; requests while busy=1 SHALL be ignored without error.
REQ-025 Accepted A write SHALL update only bytes with a_be[i]=1; a_be=0 SHALL leave memory unchanged; no read, a_rvalid stays 0.
REQ-026 Accepted read SHALL drive dout and rvalid=1 exactly READ_LATENCY cycles later; dout SHALL hold its value until next rvalid.
REQ-027 Both ports SHALL accept one request per cycle each, back-to-back, fully pipelined.
REQ-028 A-write and B-read same address same cycle: RDW_MODE=0 returns pre-write word; RDW_MODE=1 returns word with enabled bytes replaced by a_din.
REQ-029 Out-of-range write (addr >= DEPTH) SHALL be dropped; out-of-range read SHALL return 0 with rvalid per REQ-026; both SHALL set oor_err.
REQ-030 FSM states IDLE, CLEAR. IDLE->CLEAR on clr_req=1 (or first cycle after reset release when CLEAR_ON_RESET=1); busy=1 from the next cycle.
REQ-031 CLEAR SHALL write 0 to one word per cycle, address 0 ascending to DEPTH-1, then return to IDLE; busy=1 for exactly DEPTH cycles.
REQ-032 clr_req while busy=1 SHALL be ignored (no restart); clr_req and an en in the same IDLE cycle: request is accepted, sweep starts next cycle.
REQ-033 Reads in flight when CLEAR starts SHALL still complete with pre-clear data.
REQ-034 Sweep counter SHALL be ADDRESS_WIDTH bits and SHALL not wrap past DEPTH-1.

Reset
REQ-035 rst_n=0 SHALL asynchronously force: a_dout=0, b_dout=0, a_rvalid=0, b_rvalid=0, busy=0, oor_err=0, FSM=IDLE, read pipelines flushed.
REQ-036 Memory contents SHALL NOT be altered by reset; reset mid-sweep SHALL abort the sweep, leaving partly cleared memory.
REQ-037 oor_err SHALL clear only on reset.

Verification
REQ-038 A write addr 5, din 0xAABBCCDD, be 4'b1111; then A read addr 5 -> a_rvalid after READ_LATENCY, a_dout=0xAABBCCDD.
REQ-039 Word 5 = 0xAABBCCDD; write din 0x11223344, be 4'b0101 -> read returns 0xAA22CC44.
REQ-040 Word 7 = 0x0; same cycle A write addr 7 0xFFFFFFFF be 1111, B read addr 7 -> b_dout 0x0 (RDW_MODE=0) / 0xFFFFFFFF (RDW_MODE=1).
REQ-041 DEPTH=16, fill all words non-zero, pulse clr_req -> busy high 16 cycles, requests ignored, then all reads return 0.
REQ-042 DEPTH=3000, read addr 3500 -> dout 0, rvalid 1, oor_err 1; write addr 3500 leaves words 0..2999 unchanged.
REQ-043 Assert rst_n=0 mid-sweep at word 8 -> busy=0 and outputs 0 immediately; words 0..7 read 0, words 9..15 retain prior data.
